// File: rtl/tlc_pkg.sv
// Shared types, lamp encodings and default phase durations for the
// traffic-light phase sequencer.
package tlc_pkg;

    typedef enum logic [2:0] {
        MAIN_G     = 3'd0,
        MAIN_Y     = 3'd1,
        AR_TO_SIDE = 3'd2,
        SIDE_G     = 3'd3,
        SIDE_Y     = 3'd4,
        AR_TO_MAIN = 3'd5
    } phase_t;

    // {R,Y,G}, exactly one bit set
    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_R = 3'b100;
    localparam lamp_t LAMP_Y = 3'b010;
    localparam lamp_t LAMP_G = 3'b001;

    // Default durations in prescaler ticks
    localparam int TLC_N_DEF = 4;
    localparam int T_MG_DEF  = 6;
    localparam int T_Y_DEF   = 3;
    localparam int T_AR_DEF  = 1;
    localparam int T_SG_DEF  = 5;

    // Main-road lamp shown in a given phase; red whenever the side road may move
    function automatic lamp_t main_lamp_of(input phase_t p);
        case (p)
            MAIN_G:  return LAMP_G;
            MAIN_Y:  return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

    // Side-road lamp shown in a given phase
    function automatic lamp_t side_lamp_of(input phase_t p);
        case (p)
            SIDE_G:  return LAMP_G;
            SIDE_Y:  return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/tlc_sync.sv
// Two-flop synchroniser for an asynchronous level input. With RISE=1 the
// output is a one-clk pulse on each synchronised rising edge instead of
// the synchronised level.
module tlc_sync #(
    parameter bit RISE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    generate
        if (RISE) begin : g_rise
            logic r_prev;

            // Previous synchronised value for edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_sync = r_sync & ~r_prev;
        end else begin : g_level
            assign o_sync = r_sync;
        end
    endgenerate

endmodule

// File: rtl/tlc_phase_fsm.sv
// Traffic-light phase sequencer. Drives an external countdown timer by
// loading it with each phase duration, steps on expiry (count of zero on
// a cycle that is not the load cycle), and serves latched side-car and
// pedestrian requests.
module tlc_phase_fsm
    import tlc_pkg::*;
#(
    parameter int N    = TLC_N_DEF,
    parameter int T_MG = T_MG_DEF,
    parameter int T_Y  = T_Y_DEF,
    parameter int T_AR = T_AR_DEF,
    parameter int T_SG = T_SG_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         car_sense,
    input  logic         ped_req,
    input  logic         hold,
    input  logic [N-1:0] timer_val,
    output logic         tmr_load,
    output logic [N-1:0] tmr_init,
    output logic         tmr_en,
    output lamp_t        main_lamp,
    output lamp_t        side_lamp,
    output logic         walk
);

    logic         w_car_set;
    logic         w_ped_set;
    logic         w_exp;
    logic         w_step;
    logic         w_enter_sg;
    phase_t       w_next;
    logic [N-1:0] w_dur;

    phase_t       r_state;
    logic         r_load;
    logic [N-1:0] r_init;
    logic         r_en;
    lamp_t        r_main;
    lamp_t        r_side;
    logic         r_walk;
    logic         r_walk_q;
    logic         r_car_pend;
    logic         r_ped_pend;

    // Car presence is a level; the pedestrian button may be held, so only its edge counts
    tlc_sync #(.RISE(1'b0)) u_car_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (car_sense),
        .o_sync  (w_car_set)
    );

    tlc_sync #(.RISE(1'b1)) u_ped_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ped_req),
        .o_sync  (w_ped_set)
    );

    // During the load cycle the timer still shows its old (zero) count, so it
    // is not trusted; while frozen the phase must not advance either.
    assign w_exp = (timer_val == '0) && !r_load && r_en;

    // Next phase; unreachable encodings fall back to the all-red clearance
    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_G:     if (w_exp && (r_car_pend || r_ped_pend)) w_next = MAIN_Y;
            MAIN_Y:     if (w_exp) w_next = AR_TO_SIDE;
            AR_TO_SIDE: if (w_exp) w_next = SIDE_G;
            SIDE_G:     if (w_exp) w_next = SIDE_Y;
            SIDE_Y:     if (w_exp) w_next = AR_TO_MAIN;
            AR_TO_MAIN: if (w_exp) w_next = MAIN_G;
            default:    w_next = AR_TO_MAIN;
        endcase
    end

    assign w_step     = (w_next != r_state);
    assign w_enter_sg = w_step && (w_next == SIDE_G);

    // Duration loaded into the timer for the phase being entered
    always_comb begin
        case (w_next)
            MAIN_G:         w_dur = N'(T_MG);
            MAIN_Y, SIDE_Y: w_dur = N'(T_Y);
            SIDE_G:         w_dur = N'(T_SG);
            default:        w_dur = N'(T_AR);
        endcase
    end

    // Phase register, timer handshake, request latches and registered lamp outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= AR_TO_MAIN;
            r_load     <= 1'b1;
            r_init     <= N'(T_AR);
            r_en       <= 1'b1;
            r_main     <= LAMP_R;
            r_side     <= LAMP_R;
            r_walk     <= 1'b0;
            r_walk_q   <= 1'b0;
            r_car_pend <= 1'b0;
            r_ped_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= w_step;
            if (w_step) begin
                r_init <= w_dur;
            end
            r_en   <= !hold;
            r_main <= main_lamp_of(w_next);
            r_side <= side_lamp_of(w_next);
            // Entering SIDE_G serves the pending requests; a request seen on
            // that very cycle survives for the next cycle.
            if (w_enter_sg) begin
                r_car_pend <= w_car_set;
                r_ped_pend <= w_ped_set;
                r_walk_q   <= r_ped_pend;
            end else begin
                r_car_pend <= r_car_pend | w_car_set;
                r_ped_pend <= r_ped_pend | w_ped_set;
            end
            r_walk <= (w_next == SIDE_G) && (w_enter_sg ? r_ped_pend : r_walk_q);
        end
    end

    assign tmr_load  = r_load;
    assign tmr_init  = r_init;
    assign tmr_en    = r_en;
    assign main_lamp = r_main;
    assign side_lamp = r_side;
    assign walk      = r_walk;

endmodule

// File: tb/tb_tlc_phase_fsm.sv
// Bench for tlc_phase_fsm with a behavioural countdown timer and a
// prescaler tick every 4 clk. Expected transitions are queued as stimulus
// is applied and checked each time the sequencer strobes a timer load.
module tb_tlc_phase_fsm;
    import tlc_pkg::*;

    localparam int N  = 4;
    localparam int MG = 6;
    localparam int YY = 3;
    localparam int AR = 1;
    localparam int SG = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         car_sense = 1'b0;
    logic         ped_req = 1'b0;
    logic         hold = 1'b0;
    logic [N-1:0] timer_val;
    logic         tmr_load;
    logic [N-1:0] tmr_init;
    logic         tmr_en;
    lamp_t        main_lamp;
    lamp_t        side_lamp;
    logic         walk;

    int checks = 0;
    int failures = 0;

    logic [1:0] div = 2'd0;
    logic       clk_en;
    int         tick_cnt;

    typedef struct {
        string        tag;
        lamp_t        m;
        lamp_t        s;
        logic         w;
        logic [N-1:0] init;
        int           ticks;
    } exp_t;

    exp_t sb[$];
    logic cur_walk  = 1'b0;
    logic last_load = 1'b1;
    logic last_rst  = 1'b1;

    always #5 clk = ~clk;

    tlc_phase_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .car_sense (car_sense),
        .ped_req   (ped_req),
        .hold      (hold),
        .timer_val (timer_val),
        .tmr_load  (tmr_load),
        .tmr_init  (tmr_init),
        .tmr_en    (tmr_en),
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .walk      (walk)
    );

    // Prescaler: one tick every 4 clk
    always @(posedge clk) div <= div + 2'd1;
    assign clk_en = (div == 2'd3);

    // Countdown timer; counts decrements since the last load
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_val <= '1;
            tick_cnt  <= 0;
        end else if (tmr_load) begin
            timer_val <= tmr_init;
            tick_cnt  <= 0;
        end else if (tmr_en && clk_en && timer_val != '0) begin
            timer_val <= timer_val - 1'b1;
            tick_cnt  <= tick_cnt + 1;
        end
    end

    // Transition scoreboard and always-on invariants
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tmr_load && !last_load) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_load got main=%b side=%b init=%0d required=no_transition",
                           main_lamp, side_lamp, tmr_init);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("TXN %s main=%b side=%b walk=%b init=%0d ticks=%0d", e.tag,
                             main_lamp, side_lamp, walk, tmr_init, tick_cnt);
                    checks++;
                    assert (main_lamp === e.m) else begin
                        failures++; $error("FAIL %s main_lamp got=%b required=%b", e.tag, main_lamp, e.m);
                    end
                    checks++;
                    assert (side_lamp === e.s) else begin
                        failures++; $error("FAIL %s side_lamp got=%b required=%b", e.tag, side_lamp, e.s);
                    end
                    checks++;
                    assert (walk === e.w) else begin
                        failures++; $error("FAIL %s walk got=%b required=%b", e.tag, walk, e.w);
                    end
                    checks++;
                    assert (tmr_init === e.init) else begin
                        failures++; $error("FAIL %s tmr_init got=%0d required=%0d", e.tag, tmr_init, e.init);
                    end
                    checks++;
                    assert (tick_cnt === e.ticks) else begin
                        failures++; $error("FAIL %s prev_phase_ticks got=%0d required=%0d", e.tag, tick_cnt, e.ticks);
                    end
                    cur_walk = e.w;
                end
            end
            checks++;
            assert (main_lamp == LAMP_R || side_lamp == LAMP_R) else begin
                failures++; $error("FAIL both_non_red got main=%b side=%b required=one_red", main_lamp, side_lamp);
            end
            checks++;
            assert ($onehot(main_lamp) && $onehot(side_lamp)) else begin
                failures++; $error("FAIL lamp_onehot got main=%b side=%b required=onehot", main_lamp, side_lamp);
            end
            checks++;
            assert (walk === ((side_lamp == LAMP_G) ? cur_walk : 1'b0)) else begin
                failures++; $error("FAIL walk_level got=%b required=%b side=%b", walk,
                                   (side_lamp == LAMP_G) ? cur_walk : 1'b0, side_lamp);
            end
            checks++;
            assert (!(tmr_load && last_load && !last_rst)) else begin
                failures++; $error("FAIL load_width got=2+clk required=1clk");
            end
        end
        last_load = tmr_load;
        last_rst  = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            failures++;
            $error("FAIL %s got=%0h required=%0h", tag, got, req);
        end
        $display("CHK %s got=%0h required=%0h", tag, got, req);
    endtask

    task automatic push(input string tag, input lamp_t m, input lamp_t s, input logic w,
                        input int init, input int ticks);
        exp_t e;
        e.tag   = tag;
        e.m     = m;
        e.s     = s;
        e.w     = w;
        e.init  = N'(init);
        e.ticks = ticks;
        sb.push_back(e);
    endtask

    // One full side-road service starting from an expiring MAIN_G
    task automatic push_cycle(input string pfx, input logic w);
        push({pfx, "_main_y"},     LAMP_Y, LAMP_R, 1'b0, YY, MG);
        push({pfx, "_ar_to_side"}, LAMP_R, LAMP_R, 1'b0, AR, YY);
        push({pfx, "_side_g"},     LAMP_R, LAMP_G, w,    SG, AR);
        push({pfx, "_side_y"},     LAMP_R, LAMP_Y, 1'b0, YY, SG);
        push({pfx, "_ar_to_main"}, LAMP_R, LAMP_R, 1'b0, AR, YY);
        push({pfx, "_main_g"},     LAMP_G, LAMP_R, 1'b0, MG, AR);
    endtask

    task automatic wait_q(input int n, input string tag);
        int k;
        k = 0;
        while (sb.size() > n && k < 400) begin
            step();
            k++;
        end
        checks++;
        assert (sb.size() <= n) else begin
            failures++;
            $error("FAIL %s_timeout got_pending=%0d required<=%0d", tag, sb.size(), n);
        end
    endtask

    task automatic wait_tv(input int v, input string tag);
        int k;
        k = 0;
        while (timer_val !== N'(v) && k < 200) begin
            step();
            k++;
        end
        checks++;
        assert (timer_val === N'(v)) else begin
            failures++;
            $error("FAIL %s_timeout got=%0d required=%0d", tag, timer_val, v);
        end
    endtask

    initial begin
        logic [N-1:0] tv_frz;
        lamp_t        m_frz;
        lamp_t        s_frz;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_main_lamp", 32'(main_lamp), 32'(LAMP_R));
        chk("rst_side_lamp", 32'(side_lamp), 32'(LAMP_R));
        chk("rst_walk",      32'(walk),      32'd0);
        chk("rst_tmr_load",  32'(tmr_load),  32'd1);
        chk("rst_tmr_init",  32'(tmr_init),  32'(AR));
        chk("rst_tmr_en",    32'(tmr_en),    32'd1);

        // No requests: enter MAIN_G after one all-red tick and park there
        push("s1_main_g", LAMP_G, LAMP_R, 1'b0, MG, AR);
        rst = 1'b0;
        wait_q(0, "s1_enter");
        repeat (60) step();
        chk("s1_park_main", 32'(main_lamp), 32'(LAMP_G));
        chk("s1_park_timer", 32'(timer_val), 32'd0);

        // Side car: full service cycle with walk off
        car_sense = 1'b1;
        push_cycle("s2", 1'b0);
        wait_q(5, "s2_main_y");
        car_sense = 1'b0;
        wait_q(3, "s2_side_g");

        // Pedestrian press during a walk-less SIDE_G: stays pending for next cycle
        repeat (6) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        push_cycle("s4", 1'b1);
        wait_q(6, "s2_done");
        wait_q(3, "s4_side_g");

        // Freeze mid-SIDE_G
        wait_tv(3, "s5_tv3");
        hold = 1'b1;
        repeat (3) step();
        tv_frz = timer_val;
        m_frz  = main_lamp;
        s_frz  = side_lamp;
        repeat (20) step();
        chk("s5_hold_tmr_en", 32'(tmr_en), 32'd0);
        chk("s5_hold_timer",  32'(timer_val), 32'(tv_frz));
        chk("s5_hold_main",   32'(main_lamp), 32'(m_frz));
        chk("s5_hold_side",   32'(side_lamp), 32'(LAMP_G));
        chk("s5_hold_side_c", 32'(side_lamp), 32'(s_frz));
        hold = 1'b0;
        wait_q(0, "s4_done");

        // Pedestrian pulse at tick 2 of MAIN_G
        wait_tv(MG - 2, "s3_tick2");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        push_cycle("s3", 1'b1);
        wait_q(0, "s3_done");
        repeat (40) step();
        chk("s3_park_main", 32'(main_lamp), 32'(LAMP_G));
        chk("s3_park_timer", 32'(timer_val), 32'd0);

        // Reset in the middle of MAIN_Y
        car_sense = 1'b1;
        push("s6_main_y", LAMP_Y, LAMP_R, 1'b0, YY, MG);
        wait_q(0, "s6_main_y");
        car_sense = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("s6_rst_main", 32'(main_lamp), 32'(LAMP_R));
        chk("s6_rst_side", 32'(side_lamp), 32'(LAMP_R));
        repeat (2) step();
        chk("s6_rst_walk", 32'(walk), 32'd0);
        push("s6_main_g", LAMP_G, LAMP_R, 1'b0, MG, AR);
        rst = 1'b0;
        #1;
        chk("s6_rel_load", 32'(tmr_load), 32'd1);
        chk("s6_rel_init", 32'(tmr_init), 32'(AR));
        wait_q(0, "s6_main_g");
        repeat (40) step();
        chk("s6_park_main", 32'(main_lamp), 32'(LAMP_G));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
